// File: rtl/board_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : board_io_pkg
// Description : Shared types and helper functions for the board input
//               conditioning logic (channel FSM states, width helpers).
// Revision    : 1.0 - initial release
// ============================================================================
package board_io_pkg;

  // Milliseconds per second, used to derive the 1 ms tick divider.
  localparam int MS_PER_S = 1000;

  // Per-channel press-tracking state.
  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    REPEAT   = 2'd2
  } ch_state_t;

  // Ceiling log2, never less than 1 so that counters always have a bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        w = i + 1;
      end
    end
    return (w < 1) ? 1 : w;
  endfunction

  // Largest of three integers.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage : board_io_pkg
`default_nettype wire

// File: rtl/key_channel.sv
`default_nettype none
// ============================================================================
// Module      : key_channel
// Description : One input channel: synchroniser, tick-based debounce,
//               press/release edge pulses and long-press/auto-repeat FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module key_channel
  import board_io_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int DB_W   = clog2_min1(DEBOUNCE_MS + 1);
  localparam int HOLD_W = clog2_min1(max3(LONG_MS, REPEAT_MS, 1) + 1);

  // Raw pin value when the key is not pressed.
  localparam logic c_IDLE_RAW = (ACTIVE_LOW != 0);

  localparam logic [DB_W-1:0]   c_DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] c_LONG_LAST = HOLD_W'(LONG_MS - 1);
  localparam logic [HOLD_W-1:0] c_REP_LAST  = HOLD_W'(REPEAT_MS - 1);
  localparam logic              c_LONG_EN   = (LONG_MS > 0);
  localparam logic              c_REP_EN    = (REPEAT_MS > 0);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic [DB_W-1:0]        r_db_cnt;
  logic                   r_level;
  logic                   r_level_d;
  logic                   r_press;
  logic                   r_release;
  ch_state_t              r_state;
  ch_state_t              w_state_nxt;
  logic [HOLD_W-1:0]      r_hold;
  logic [HOLD_W-1:0]      w_hold_nxt;
  logic                   r_long;
  logic                   w_long_nxt;

  // Synchroniser chain; resets to the idle pin level so no false press appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{c_IDLE_RAW}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // Polarity-normalised synchronised input: 1 means pressed.
  assign w_s = r_sync[SYNC_STAGES-1] ^ c_IDLE_RAW;

  // Debounce: the level flips only after DEBOUNCE_MS consecutive disagreeing ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_cnt <= '0;
      r_level  <= 1'b0;
    end else if (w_s == r_level) begin
      r_db_cnt <= '0;
    end else if (i_tick) begin
      if (r_db_cnt == c_DB_LAST) begin
        r_level  <= ~r_level;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  // Edge pulses registered one cycle after the debounced level changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      r_release <= ~r_level & r_level_d;
    end
  end

  // Hold-tracking FSM state, hold counter and registered long-press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RELEASED;
      r_hold  <= '0;
      r_long  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_long  <= w_long_nxt;
    end
  end

  // Next-state logic; a released level wins over any pulse due this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_long_nxt  = 1'b0;
    if (!r_level) begin
      w_state_nxt = RELEASED;
      w_hold_nxt  = '0;
    end else begin
      unique case (r_state)
        RELEASED: begin
          w_state_nxt = PRESSED;
          w_hold_nxt  = '0;
        end
        PRESSED: begin
          if (c_LONG_EN && i_tick) begin
            if (r_hold == c_LONG_LAST) begin
              w_long_nxt  = 1'b1;
              w_hold_nxt  = '0;
              w_state_nxt = REPEAT;
            end else begin
              w_hold_nxt = r_hold + HOLD_W'(1);
            end
          end
        end
        REPEAT: begin
          if (c_REP_EN && i_tick) begin
            if (r_hold == c_REP_LAST) begin
              w_long_nxt = 1'b1;
              w_hold_nxt = '0;
            end else begin
              w_hold_nxt = r_hold + HOLD_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = RELEASED;
          w_hold_nxt  = '0;
        end
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;

endmodule : key_channel
`default_nettype wire

// File: rtl/board_key_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : board_key_conditioner
// Description : NUM_CH-channel key/switch conditioner with a shared 1 ms
//               prescaler; exports level, press, release and long pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module board_key_conditioner
  import board_io_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [NUM_CH-1:0] key_raw,
  output logic [NUM_CH-1:0] key_level,
  output logic [NUM_CH-1:0] key_press,
  output logic [NUM_CH-1:0] key_release,
  output logic [NUM_CH-1:0] key_long,
  output logic              tick_ms
);

  // Cycles per millisecond; clamped so very slow clocks still tick every cycle.
  localparam int TICK_DIV = ((CLK_HZ / MS_PER_S) < 1) ? 1 : (CLK_HZ / MS_PER_S);
  localparam int PRE_W    = clog2_min1(TICK_DIV);
  localparam logic [PRE_W-1:0] c_PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] r_pre_cnt;
  logic             w_tick;

  assign w_tick  = (r_pre_cnt == c_PRE_LAST);
  assign tick_ms = w_tick;

  // Free-running prescaler 0..TICK_DIV-1 shared by every channel.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_pre_cnt <= '0;
    end else if (w_tick) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + PRE_W'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    key_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .ACTIVE_LOW  (ACTIVE_LOW),
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS),
      .REPEAT_MS   (REPEAT_MS)
    ) u_ch (
      .clk       (clk_clk),
      .rst       (reset_reset),
      .i_tick    (w_tick),
      .i_raw     (key_raw[gi]),
      .o_level   (key_level[gi]),
      .o_press   (key_press[gi]),
      .o_release (key_release[gi]),
      .o_long    (key_long[gi])
    );
  end : g_ch

endmodule : board_key_conditioner
`default_nettype wire
